// File: rtl/stim_pkg.sv
// Shared types and default widths for the stimulus playback port.
package stim_pkg;
  localparam int STIM_DEPTH  = 16;
  localparam int STIM_VAL_W  = 18;
  localparam int STIM_TIME_W = 64;

  typedef struct packed {
    logic [STIM_TIME_W-1:0]       t;
    logic signed [STIM_VAL_W-1:0] v;
    logic                         sel;
  } stim_entry_t;

  function automatic logic is_due(
    input logic [STIM_TIME_W-1:0] now,
    input logic [STIM_TIME_W-1:0] t
  );
    return now >= t;
  endfunction
endpackage

// File: rtl/stim_fifo.sv
// Show-ahead FIFO of timestamped stimulus entries.
module stim_fifo
  import stim_pkg::*;
#(
  parameter int DEPTH = STIM_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  stim_entry_t wdata,
  output stim_entry_t head,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  stim_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = r_count == (AW+1)'(DEPTH);
  assign empty  = r_count == '0;
  assign count  = r_count;
  assign head   = r_mem[r_rptr];
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  // flush drops any same-cycle push as well as the queued entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/stim_playback_port.sv
// Applies queued timestamped stimulus to the emulator once emu_time
// reaches each entry's timestamp; outputs hold the last applied value.
module stim_playback_port
  import stim_pkg::*;
#(
  parameter int DEPTH      = STIM_DEPTH,
  parameter int VAL_WIDTH  = STIM_VAL_W,
  parameter int TIME_WIDTH = STIM_TIME_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                        emu_clk,
  input  logic                        emu_rst,
  input  logic [TIME_WIDTH-1:0]       emu_time,
  input  logic                        arm,
  input  logic                        flush,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [TIME_WIDTH-1:0]       wr_time,
  input  logic signed [VAL_WIDTH-1:0] wr_value,
  input  logic                        wr_sel,
  output logic signed [VAL_WIDTH-1:0] i_in_stim,
  output logic                        digital_sel_stim,
  output logic [CW-1:0]               stim_count,
  output logic                        stim_empty,
  output logic                        late_flag
);
  stim_entry_t w_wr;
  stim_entry_t w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_arm_rise;

  logic signed [VAL_WIDTH-1:0] r_val;
  logic                        r_sel;
  logic                        r_late;
  logic                        r_arm_q;

  assign w_wr.t   = wr_time;
  assign w_wr.v   = wr_value;
  assign w_wr.sel = wr_sel;

  assign w_push = wr_valid && !w_full && !flush;
  assign w_pop  = arm && !w_empty && !flush &&
                  is_due(emu_time, w_head.t);
  assign w_arm_rise = arm && !r_arm_q;

  stim_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (emu_clk),
    .rst   (emu_rst),
    .flush (flush),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wr),
    .head  (w_head),
    .count (stim_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // re-arming clears late_flag even if a late pop lands on the same edge
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      r_val   <= '0;
      r_sel   <= 1'b0;
      r_late  <= 1'b0;
      r_arm_q <= 1'b0;
    end else begin
      r_arm_q <= arm;
      if (w_pop) begin
        r_val <= w_head.v;
        r_sel <= w_head.sel;
      end
      if (w_arm_rise) r_late <= 1'b0;
      else if (w_pop && emu_time > w_head.t) r_late <= 1'b1;
    end
  end

  assign wr_ready         = !w_full;
  assign stim_empty       = w_empty;
  assign i_in_stim        = r_val;
  assign digital_sel_stim = r_sel;
  assign late_flag        = r_late;
endmodule

// File: tb/tb_stim_playback_port.sv
// Scoreboard bench for stim_playback_port.
module tb_stim_playback_port;
  logic               clk = 1'b0;
  logic               emu_rst;
  logic [63:0]        emu_time;
  logic               arm;
  logic               flush;
  logic               wr_valid;
  logic               wr_ready;
  logic [63:0]        wr_time;
  logic signed [17:0] wr_value;
  logic               wr_sel;
  logic signed [17:0] i_in_stim;
  logic               digital_sel_stim;
  logic [4:0]         stim_count;
  logic               stim_empty;
  logic               late_flag;

  typedef struct {
    longint v;
    logic   sel;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  stim_playback_port dut (
    .emu_clk          (clk),
    .emu_rst          (emu_rst),
    .emu_time         (emu_time),
    .arm              (arm),
    .flush            (flush),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_time          (wr_time),
    .wr_value         (wr_value),
    .wr_sel           (wr_sel),
    .i_in_stim        (i_in_stim),
    .digital_sel_stim (digital_sel_stim),
    .stim_count       (stim_count),
    .stim_empty       (stim_empty),
    .late_flag        (late_flag)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input longint t, input longint v, input logic s);
    exp_t e;
    wr_valid = 1'b1;
    wr_time  = 64'(t);
    wr_value = 18'(v);
    wr_sel   = s;
    e.v      = v;
    e.sel    = s;
    sb.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_val"}, i_in_stim, e.v);
      check({tag, "_sel"}, digital_sel_stim, e.sel);
    end
  endtask

  initial begin
    emu_rst  = 1'b1;
    emu_time = '0;
    arm      = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_time  = '0;
    wr_value = '0;
    wr_sel   = 1'b0;
    #12;
    check("rst_val", i_in_stim, 0);
    check("rst_empty", stim_empty, 1);
    check("rst_ready", wr_ready, 1);
    check("rst_count", stim_count, 0);
    check("rst_late", late_flag, 0);
    @(negedge clk);
    emu_rst = 1'b0;
    tick();

    // timing: single entry at t=100, time steps by 10
    offer(100, 500, 1'b1);
    tick();
    wr_valid = 1'b0;
    arm = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      emu_time = 64'(k * 10);
      tick();
      if (k < 10) begin
        if (k == 9) check("tim_hold", i_in_stim, 0);
        if (k == 9) check("tim_cnt", stim_count, 1);
      end else begin
        check_pop("tim");
      end
    end
    check("tim_late", late_flag, 0);

    // backlog: three expired entries drain on consecutive edges
    arm = 1'b0;
    emu_time = '0;
    for (int i = 1; i <= 3; i++) begin
      offer(i * 10, i, 1'b0);
      tick();
    end
    wr_valid = 1'b0;
    emu_time = 64'd50;
    arm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pop("blog");
    end
    check("blog_late", late_flag, 1);
    check("blog_empty", stim_empty, 1);

    // reset mid-playback with nonzero outputs and a queued entry
    offer(1000, 77, 1'b1);
    tick();
    wr_valid = 1'b0;
    sb.delete();
    #2;
    emu_rst = 1'b1;
    #1;
    check("mrst_val", i_in_stim, 0);
    check("mrst_sel", digital_sel_stim, 0);
    check("mrst_empty", stim_empty, 1);
    check("mrst_ready", wr_ready, 1);
    check("mrst_late", late_flag, 0);
    arm = 1'b0;
    emu_time = '0;
    @(negedge clk);
    emu_rst = 1'b0;
    tick();

    // full: 16 entries, a refused 17th, then one pop frees a slot
    arm = 1'b1;
    for (int i = 0; i < 16; i++) begin
      offer(1000, 100 + i, i[0]);
      tick();
    end
    check("full_ready", wr_ready, 0);
    check("full_cnt", stim_count, 16);
    wr_valid = 1'b1;
    wr_value = 18'sd999;
    wr_time  = 64'd0;
    tick();
    check("full_cnt17", stim_count, 16);
    check("full_nopop", i_in_stim, 0);
    emu_time = 64'd1000;
    tick();
    wr_valid = 1'b0;
    check_pop("full_pop");
    check("full_cnt15", stim_count, 15);
    check("full_ready1", wr_ready, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check_pop("full_drain");
    end
    check("full_empty", stim_empty, 1);
    check("full_late", late_flag, 0);

    // control: disarmed hold, then flush beating a push
    arm = 1'b0;
    offer(5, -7, 1'b0);
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    check("ctl_hold_val", i_in_stim, 115);
    check("ctl_hold_sel", digital_sel_stim, 1);
    check("ctl_cnt", stim_count, 1);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_value = 18'sd42;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    sb.delete();
    check("fl_cnt", stim_count, 0);
    check("fl_empty", stim_empty, 1);
    check("fl_val", i_in_stim, 115);
    arm = 1'b1;
    tick();
    check("fl_val2", i_in_stim, 115);
    check("fl_cnt2", stim_count, 0);

    // wrap: 40 push/pop pairs streaming through the FIFO
    emu_time = 64'd2000;
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) offer(0, 1000 + i, i[1]);
      else wr_valid = 1'b0;
      tick();
      if (i >= 1) check_pop("wrap");
      if (i == 20) check("wrap_cnt", stim_count, 1);
    end
    check("wrap_empty", stim_empty, 1);
    check("wrap_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
